// File: rtl/exp_pkg.sv
// Shared state type and elaboration-time constant helpers for the exp_taylor_seq unit.
// The optional EXP_SAT_EN macro is consumed by the files that import this package.
package exp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_Z = 2'd1,
    MUL_R = 2'd2,
    DONE  = 2'd3
  } exp_state_e;

  function automatic longint one_f(input int frac);
    return longint'(1) << frac;
  endfunction

  // round(2^frac / k); k == 0 has no series term and maps to zero.
  function automatic longint recip_f(input int k, input int frac, input int width);
    longint r;
    if (k <= 0) return 0;
    r = (one_f(frac) + longint'(k / 2)) / longint'(k);
    if (width < 64) r = r & ((longint'(1) << width) - 1);
    return r;
  endfunction

endpackage

// File: rtl/exp_fx_mul.sv
// Combinational signed fixed-point multiply, round-half-up to FRAC bits, optional +ONE.
// With EXP_SAT_EN defined every intermediate clamps to the WIDTH range and ovf flags it.
module exp_fx_mul
  import exp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    add_one,
  output logic signed [WIDTH-1:0] y
`ifdef EXP_SAT_EN
  ,
  output logic                    ovf
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0]    UNIT_P = PW'(1);
  localparam logic signed [PW-1:0]    HALF_P = UNIT_P <<< (FRAC - 1);
  localparam logic signed [WIDTH-1:0] ONE_W  = WIDTH'(one_f(FRAC));

  logic signed [PW-1:0] prod_p;

  assign prod_p = PW'(a) * PW'(b);

  function automatic logic signed [PW-1:0] rnd_f(input logic signed [PW-1:0] p);
    return (p + HALF_P) >>> FRAC;
  endfunction

`ifdef EXP_SAT_EN
  localparam logic signed [PW-1:0]    MAX_P = (UNIT_P <<< (WIDTH - 1)) - UNIT_P;
  localparam logic signed [PW-1:0]    MIN_P = -(UNIT_P <<< (WIDTH - 1));
  localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic fits_f(input logic signed [PW-1:0] v);
    return (v <= MAX_P) && (v >= MIN_P);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_f(input logic signed [PW-1:0] v);
    if (v > MAX_P) return MAX_W;
    if (v < MIN_P) return MIN_W;
    return WIDTH'(v);
  endfunction

  logic signed [PW-1:0]    rnd_p;
  logic signed [PW-1:0]    sum_p;
  logic signed [WIDTH-1:0] r_w;
  logic                    r_ovf;

  always_comb begin
    rnd_p = rnd_f(prod_p);
    r_w   = sat_f(rnd_p);
    r_ovf = !fits_f(rnd_p);
    sum_p = PW'(r_w) + PW'(ONE_W);
    if (add_one) begin
      y   = sat_f(sum_p);
      ovf = r_ovf || !fits_f(sum_p);
    end else begin
      y   = r_w;
      ovf = r_ovf;
    end
  end
`else
  logic signed [WIDTH-1:0] r_w;

  // Without saturation both the rounded product and the +ONE simply wrap.
  always_comb begin
    r_w = WIDTH'(rnd_f(prod_p));
    y   = add_one ? r_w + ONE_W : r_w;
  end
`endif

endmodule

// File: rtl/exp_taylor_seq.sv
// Sequential fixed-point e^z: Horner evaluation of an N_TERMS Taylor series, two cycles per term.
// Define EXP_SAT_EN for saturating arithmetic and the out_ovf flag; otherwise results wrap.
module exp_taylor_seq
  import exp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FRAC    = 16,
  parameter int N_TERMS = 21
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data
`ifdef EXP_SAT_EN
  ,
  output logic                    out_ovf
`endif
);

  localparam int KW = $clog2(N_TERMS);
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(one_f(FRAC));

  if (N_TERMS < 2) begin : g_bad_terms
    $error("exp_taylor_seq: N_TERMS must be at least 2");
  end
  if (FRAC < 1 || FRAC > WIDTH - 2) begin : g_bad_frac
    $error("exp_taylor_seq: FRAC must lie in 1..WIDTH-2");
  end

  // 1/k coefficients are constants folded at elaboration; entry 0 is never addressed.
  logic signed [WIDTH-1:0] recip_tbl [N_TERMS];
  for (genvar i = 0; i < N_TERMS; i++) begin : g_recip
    assign recip_tbl[i] = WIDTH'(recip_f(i, FRAC, WIDTH));
  end

  exp_state_e              state;
  logic signed [WIDTH-1:0] z_q;
  logic signed [WIDTH-1:0] acc;
  logic [KW-1:0]           k;
  logic                    mul_r_sel;
  logic signed [WIDTH-1:0] mul_b;
  logic signed [WIDTH-1:0] mul_y;
`ifdef EXP_SAT_EN
  logic                    ovf_acc;
  logic                    mul_ovf;
`endif

  assign in_ready  = rst_n && (state == IDLE);
  assign mul_r_sel = (state == MUL_R);
  assign mul_b     = mul_r_sel ? recip_tbl[k] : z_q;

  exp_fx_mul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .a       (acc),
    .b       (mul_b),
    .add_one (mul_r_sel),
    .y       (mul_y)
`ifdef EXP_SAT_EN
    ,
    .ovf     (mul_ovf)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      z_q       <= '0;
      acc       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef EXP_SAT_EN
      ovf_acc   <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            z_q   <= in_data;
            acc   <= ONE;
            k     <= KW'(N_TERMS - 1);
            state <= MUL_Z;
`ifdef EXP_SAT_EN
            ovf_acc <= 1'b0;
            out_ovf <= 1'b0;
`endif
          end
        end
        MUL_Z: begin
          acc   <= mul_y;
          state <= MUL_R;
`ifdef EXP_SAT_EN
          ovf_acc <= ovf_acc | mul_ovf;
`endif
        end
        MUL_R: begin
          acc <= mul_y;
`ifdef EXP_SAT_EN
          ovf_acc <= ovf_acc | mul_ovf;
`endif
          // The k == 1 step yields 1 + z*acc, the complete series sum.
          if (k == KW'(1)) begin
            out_data  <= mul_y;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef EXP_SAT_EN
            out_ovf   <= ovf_acc | mul_ovf;
`endif
          end else begin
            k     <= k - KW'(1);
            state <= MUL_Z;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_taylor_seq.sv
// Randomized bench for exp_taylor_seq (Q16.16, 21 terms) against a series model of e^z.
// Build with EXP_SAT_EN defined to cover the saturating variant and out_ovf.
module tb_exp_taylor_seq;

  localparam int LAT = 40;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_data   = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [31:0] out_data;
`ifdef EXP_SAT_EN
  logic               out_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  exp_taylor_seq #(
    .WIDTH   (32),
    .FRAC    (16),
    .N_TERMS (21)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef EXP_SAT_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void chk_tol(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    n_vec++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", nm, act, exp, tol);
    end
  endfunction

  // Series model: e^z ~= sum z^k/k!, nested as 1 + z/1*(1 + z/2*(1 + ... )).
  function automatic longint fit(input longint v, output bit o);
`ifdef EXP_SAT_EN
    o = 1'b0;
    if (v > 64'sd2147483647) begin o = 1'b1; return 64'sd2147483647; end
    if (v < -64'sd2147483648) begin o = 1'b1; return -64'sd2147483648; end
    return v;
`else
    o = 1'b0;
    return longint'(int'(v));
`endif
  endfunction

  function automatic longint rnd(input longint p);
    return (p + 64'sd32768) >>> 16;
  endfunction

  function automatic void model_exp(input logic signed [31:0] z, output logic signed [31:0] y, output bit ovf);
    longint acc;
    longint rk;
    bit o;
    acc = 65536;
    ovf = 1'b0;
    for (int t = 20; t >= 1; t--) begin
      rk  = (65536 + t / 2) / t;
      acc = fit(rnd(acc * longint'(z)), o); ovf |= o;
      acc = fit(rnd(acc * rk), o);          ovf |= o;
      acc = fit(acc + 65536, o);            ovf |= o;
    end
    y = acc[31:0];
  endfunction

  // Transaction-level expectation: idle -> busy for LAT edges -> holding until out_ready.
  bit                 m_busy = 1'b0;
  bit                 m_done = 1'b0;
  int                 m_cnt  = 0;
  logic signed [31:0] m_res  = '0;
  bit                 m_res_ovf = 1'b0;
  logic signed [31:0] m_out  = '0;
  bit                 m_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_out = '0; m_ovf = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_out = m_res; m_ovf = m_res_ovf;
      end
    end else if (in_valid) begin
      model_exp(in_data, m_res, m_res_ovf);
      m_busy = 1'b1; m_cnt = LAT; m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", longint'(in_ready), longint'(rst_n && !m_busy && !m_done));
      chk("out_valid", longint'(out_valid), longint'(m_done));
      chk("out_data", out_data, m_out);
`ifdef EXP_SAT_EN
      chk("out_ovf", longint'(out_ovf), longint'(m_ovf));
`endif
    end
  end

  task automatic run_op(input logic signed [31:0] z, input int stall, input bit noise,
                        output logic signed [31:0] res, output int lat);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = z;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = $urandom;
      if (!out_valid) lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) begin
      n_vec++; n_err++;
      $display("FAIL result_timeout: out_valid 0 after %0d cycles, expected 1 after %0d", lat, LAT);
    end
    repeat (stall) begin
      @(negedge clk);
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = $urandom;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    res       = out_data;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [31:0] res;
    logic signed [31:0] my;
    logic signed [31:0] z;
    bit                 mo;
    int                 lat;
    int                 stall;

    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    #2 rst_n = 1'b1;
    #1 chk("in_ready_after_rst", longint'(in_ready), 1);

    model_exp(32'sh0, my, mo);
    chk("model_z0", my, 32'h0001_0000);
    chk("model_z0_ovf", longint'(mo), 0);
    run_op(32'sh0, 0, 1'b0, res, lat);
    chk("z0_data", res, 32'h0001_0000);
    chk("z0_latency", lat, LAT);
`ifdef EXP_SAT_EN
    chk("z0_ovf", longint'(out_ovf), 0);
`endif

    model_exp(32'sh0001_0000, my, mo);
    chk_tol("model_e1", my, 32'h0002_B7E1, 4);
    run_op(32'sh0001_0000, 0, 1'b1, res, lat);
    chk_tol("e1_data", res, 32'h0002_B7E1, 4);

    model_exp(32'shFFFF_0000, my, mo);
    chk_tol("model_em1", my, 32'h0000_5E2E, 4);
    run_op(32'shFFFF_0000, 1, 1'b1, res, lat);
    chk_tol("em1_data", res, 32'h0000_5E2E, 4);

    model_exp(32'sh0002_0000, my, mo);
    chk_tol("model_e2", my, 32'h0007_639A, 4);
    run_op(32'sh0002_0000, 0, 1'b0, res, lat);
    chk_tol("e2_data", res, 32'h0007_639A, 4);

    // Downstream stall: result must hold and new requests must be ignored meanwhile.
    model_exp(32'sh0000_8000, my, mo);
    run_op(32'sh0000_8000, 10, 1'b1, res, lat);
    chk("stall_data", res, my);
    chk("stall_latency", lat, LAT);

    run_op(32'sh000B_0000, 0, 1'b0, res, lat);
`ifdef EXP_SAT_EN
    chk("sat_data", res, 32'h7FFF_FFFF);
    chk("sat_ovf", longint'(out_ovf), 1);
    run_op(32'sh0, 0, 1'b0, res, lat);
    chk("after_sat_ovf", longint'(out_ovf), 0);
    chk("after_sat_data", res, 32'h0001_0000);
`else
    model_exp(32'sh000B_0000, my, mo);
    chk("wrap_data", res, my);
`endif

    // Abort an operation part-way with the asynchronous reset.
    run_op(32'sh0002_0000, 0, 1'b0, res, lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'sh0001_8000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("midrst_release_in_ready", longint'(in_ready), 1);
    run_op(32'sh0001_0000, 0, 1'b0, res, lat);
    chk_tol("midrst_e1", res, 32'h0002_B7E1, 4);
    chk("midrst_latency", lat, LAT);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        z = $urandom;
      end else begin
        z = $urandom_range(0, 32'h0005_0000);
        if ($urandom_range(0, 1) == 1) z = -z;
      end
      stall = $urandom_range(0, 3);
      model_exp(z, my, mo);
      run_op(z, stall, 1'b1, res, lat);
      chk("rand_data", res, my);
      chk("rand_latency", lat, LAT);
`ifdef EXP_SAT_EN
      chk("rand_ovf", longint'(out_ovf), longint'(mo));
`endif
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
